// File: rtl/alarm_time_keeper.sv
// Alarm clock core: samples the 1 Hz time base and the 10 Hz set rate, keeps BCD time and alarm,
// and runs the IDLE/RING/SNOOZE alarm state machine.
module alarm_time_keeper #(
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned RING_SEC   = 60,
  parameter logic [15:0] ALARM_RST  = 16'h0600
) (
  input  logic       clk,
  input  logic       resetSW,
  input  logic       sec_clk_in,
  input  logic       set_clk_in,
  input  logic [1:0] mode,
  input  logic       inc_hr,
  input  logic       inc_min,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       dismiss,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic [7:0] alarm_hours,
  output logic [7:0] alarm_minutes,
  output logic       alarm_out,
  output logic [1:0] alarm_state
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRing   = 2'b01,
    StSnooze = 2'b10
  } state_e;

  localparam logic [8:0] RingLast   = 9'(RING_SEC - 1);
  localparam logic [8:0] SnoozeLast = 9'(SNOOZE_SEC - 1);

  // Two-digit BCD increment that wraps to 00 after lim.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    logic [7:0] r;
    if (v == lim) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  logic [2:0] sec_sync_q, set_sync_q;
  logic       sec_tick, set_tick;
  logic       set_time, set_alarm, cnt_tick, alarm_hit;

  logic [7:0] hours_q, minutes_q, seconds_q, hours_d, minutes_d, seconds_d;
  logic [7:0] al_hours_q, al_minutes_q, al_hours_d, al_minutes_d;
  logic [7:0] run_hours, run_minutes, run_seconds;

  state_e     state_q, state_d;
  logic [8:0] ring_cnt_q, ring_cnt_d, snz_cnt_q, snz_cnt_d;
  logic       alarm_out_q;

  // Bit 0 is the first sync stage, bit 2 the edge-detect history.
  assign sec_tick  = sec_sync_q[1] & ~sec_sync_q[2];
  assign set_tick  = set_sync_q[1] & ~set_sync_q[2];
  assign set_time  = (mode == 2'b01);
  assign set_alarm = (mode == 2'b10);
  assign cnt_tick  = sec_tick & ~set_time;

  always_comb begin
    run_seconds = bcd_inc(seconds_q, 8'h59);
    run_minutes = (seconds_q == 8'h59) ? bcd_inc(minutes_q, 8'h59) : minutes_q;
    run_hours   = (seconds_q == 8'h59 && minutes_q == 8'h59) ? bcd_inc(hours_q, 8'h23) : hours_q;

    hours_d      = hours_q;
    minutes_d    = minutes_q;
    seconds_d    = seconds_q;
    al_hours_d   = al_hours_q;
    al_minutes_d = al_minutes_q;

    if (set_time) begin
      seconds_d = 8'h00;
      if (set_tick && inc_min) minutes_d = bcd_inc(minutes_q, 8'h59);
      if (set_tick && inc_hr)  hours_d   = bcd_inc(hours_q, 8'h23);
    end else if (sec_tick) begin
      seconds_d = run_seconds;
      minutes_d = run_minutes;
      hours_d   = run_hours;
    end

    if (set_alarm && set_tick) begin
      if (inc_min) al_minutes_d = bcd_inc(al_minutes_q, 8'h59);
      if (inc_hr)  al_hours_d   = bcd_inc(al_hours_q, 8'h23);
    end

    // Only the tick that lands exactly on HH:MM:00 can start a ring.
    alarm_hit = cnt_tick &&
                ({run_hours, run_minutes, run_seconds} == {al_hours_q, al_minutes_q, 8'h00});
  end

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    if (!alarm_en) begin
      state_d    = StIdle;
      ring_cnt_d = '0;
      snz_cnt_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (alarm_hit) begin
            state_d    = StRing;
            ring_cnt_d = '0;
          end
        end
        StRing: begin
          if (dismiss) begin
            state_d    = StIdle;
            ring_cnt_d = '0;
          end else if (snooze) begin
            state_d   = StSnooze;
            snz_cnt_d = '0;
          end else if (cnt_tick) begin
            if (ring_cnt_q == RingLast) begin
              state_d    = StIdle;
              ring_cnt_d = '0;
            end else begin
              ring_cnt_d = ring_cnt_q + 9'd1;
            end
          end
        end
        StSnooze: begin
          if (dismiss) begin
            state_d   = StIdle;
            snz_cnt_d = '0;
          end else if (cnt_tick) begin
            if (snz_cnt_q == SnoozeLast) begin
              state_d    = StRing;
              ring_cnt_d = '0;
              snz_cnt_d  = '0;
            end else begin
              snz_cnt_d = snz_cnt_q + 9'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetSW) begin
      sec_sync_q   <= '0;
      set_sync_q   <= '0;
      hours_q      <= 8'h00;
      minutes_q    <= 8'h00;
      seconds_q    <= 8'h00;
      al_hours_q   <= ALARM_RST[15:8];
      al_minutes_q <= ALARM_RST[7:0];
    end else begin
      sec_sync_q   <= {sec_sync_q[1:0], sec_clk_in};
      set_sync_q   <= {set_sync_q[1:0], set_clk_in};
      hours_q      <= hours_d;
      minutes_q    <= minutes_d;
      seconds_q    <= seconds_d;
      al_hours_q   <= al_hours_d;
      al_minutes_q <= al_minutes_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetSW) begin
      state_q     <= StIdle;
      ring_cnt_q  <= '0;
      snz_cnt_q   <= '0;
      alarm_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ring_cnt_q  <= ring_cnt_d;
      snz_cnt_q   <= snz_cnt_d;
      alarm_out_q <= (state_d == StRing);
    end
  end

  assign hours         = hours_q;
  assign minutes       = minutes_q;
  assign seconds       = seconds_q;
  assign alarm_hours   = al_hours_q;
  assign alarm_minutes = al_minutes_q;
  assign alarm_out     = alarm_out_q;
  assign alarm_state   = state_q;

endmodule
